// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: opcodes, reset values and command FSM encoding shared by the SSD1306 driver and sink.
package ssd1306_pkg;
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] CMD_COL_ADDR    = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] CMD_INV_OFF     = 8'hA6;
    localparam logic [7:0] CMD_INV_ON      = 8'hA7;
    localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
    localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
    localparam logic [7:0] CMD_VCOMH       = 8'hDB;
    localparam logic [7:0] RESET_CONTRAST  = 8'h7F;

    typedef enum logic [1:0] {ST_CMD, ST_ARG1, ST_ARG2} cmd_state_e;

    // Opcodes whose single argument the sink swallows without acting on it.
    function automatic logic takes_discard_arg(input logic [7:0] op);
        return op inside {CMD_ADDR_MODE, CMD_CHARGE_PUMP, CMD_MUX_RATIO, CMD_DISP_OFFSET,
                          CMD_CLK_DIV, CMD_PRECHARGE, CMD_COM_PINS, CMD_VCOMH};
    endfunction
endpackage

// File: rtl/ssd1306_spi_deserializer.sv
// ssd1306_spi_deserializer: synchronises the 4-wire SPI lines and assembles MSB-first bytes with their D/C flag.
module ssd1306_spi_deserializer
    import ssd1306_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csn,
    input  logic       spi_clk,
    input  logic       spi_dcn,
    input  logic       spi_mosi,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       is_data,
    output logic       frame_error
);
    localparam logic [3:0] SYNC_RST = 4'b1000;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       dc_q, dc_d, valid_q, valid_d, ferr_q, ferr_d;
    logic       csn_s, sclk_s, dcn_s, mosi_s, rise;

    always_comb begin
        sync_d[0] = {spi_csn, spi_clk, spi_dcn, spi_mosi};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        {csn_s, sclk_s, dcn_s, mosi_s} = sync_q[SYNC_STAGES-1];
        rise = sclk_s && !sclk_prev_q && !csn_s;
        sclk_prev_d = sclk_s;
        shift_d = shift_q;
        cnt_d = cnt_q;
        byte_d = byte_q;
        dc_d = dc_q;
        valid_d = 1'b0;
        ferr_d = csn_s && cnt_q != 3'd0;
        if (csn_s) begin
            cnt_d = 3'd0;
        end else if (rise) begin
            shift_d = {shift_q[5:0], mosi_s};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                byte_d = {shift_q, mosi_s};
                dc_d = dcn_s;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{SYNC_RST}};
            sclk_prev_q <= 1'b0;
            shift_q <= '0;
            cnt_q <= '0;
            byte_q <= '0;
            dc_q <= 1'b0;
            valid_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            sclk_prev_q <= sclk_prev_d;
            shift_q <= shift_d;
            cnt_q <= cnt_d;
            byte_q <= byte_d;
            dc_q <= dc_d;
            valid_q <= valid_d;
            ferr_q <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign rx_byte = byte_q;
    assign is_data = dc_q;
    assign frame_error = ferr_q;
endmodule

// File: rtl/ssd1306_spi_sink.sv
// ssd1306_spi_sink: SSD1306 SPI receive model decoding commands and writing data bytes to a framebuffer.
// Define SSD1306_SINK_STATS_EN to add saturating command/data/error counters.
module ssd1306_spi_sink
    import ssd1306_pkg::*;
#(
    parameter int FB_COLS     = 128,
    parameter int FB_PAGES    = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CW = $clog2(FB_COLS),
    localparam int PW = $clog2(FB_PAGES),
    localparam int AW = $clog2(FB_COLS * FB_PAGES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          spi_csn,
    input  logic          spi_clk,
    input  logic          spi_dcn,
    input  logic          spi_mosi,
    output logic          fb_we,
    output logic [AW-1:0] fb_addr,
    output logic [7:0]    fb_data,
    output logic [7:0]    contrast,
    output logic          inversion,
    output logic          display_on,
`ifdef SSD1306_SINK_STATS_EN
    output logic [15:0]   cmd_count,
    output logic [15:0]   data_count,
    output logic [7:0]    error_count,
`endif
    output logic          frame_error
);
    logic       rx_valid, rx_is_data;
    logic [7:0] rx_byte;

    ssd1306_spi_deserializer #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
        .clk(clk),
        .reset(reset),
        .spi_csn(spi_csn),
        .spi_clk(spi_clk),
        .spi_dcn(spi_dcn),
        .spi_mosi(spi_mosi),
        .byte_valid(rx_valid),
        .rx_byte(rx_byte),
        .is_data(rx_is_data),
        .frame_error(frame_error)
    );

    cmd_state_e    state_q, state_d;
    logic [7:0]    op_q, op_d, arg_q, arg_d;
    logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d, col_inc;
    logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d, page_inc;
    logic          fb_we_q, fb_we_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]    fb_data_q, fb_data_d, contrast_q, contrast_d;
    logic          inversion_q, inversion_d, display_on_q, display_on_d;

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        arg_d = arg_q;
        col_d = col_q;
        col_start_d = col_start_q;
        col_end_d = col_end_q;
        page_d = page_q;
        page_start_d = page_start_q;
        page_end_d = page_end_q;
        fb_we_d = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        contrast_d = contrast_q;
        inversion_d = inversion_q;
        display_on_d = display_on_q;
        col_inc = (col_q == CW'(FB_COLS - 1)) ? '0 : col_q + CW'(1);
        page_inc = (page_q == PW'(FB_PAGES - 1)) ? '0 : page_q + PW'(1);
        // A data byte always writes, and abandons any half-received command.
        if (rx_valid && rx_is_data) begin
            state_d = ST_CMD;
            fb_we_d = 1'b1;
            fb_addr_d = AW'(page_q) * AW'(FB_COLS) + AW'(col_q);
            fb_data_d = rx_byte;
            col_d = (col_q == col_end_q) ? col_start_q : col_inc;
            page_d = (col_q != col_end_q) ? page_q : (page_q == page_end_q) ? page_start_q : page_inc;
        end else if (rx_valid && state_q == ST_CMD) begin
            op_d = rx_byte;
            state_d = (rx_byte inside {CMD_CONTRAST, CMD_COL_ADDR, CMD_PAGE_ADDR} || takes_discard_arg(rx_byte)) ? ST_ARG1 : ST_CMD;
            inversion_d = (rx_byte == CMD_INV_ON) ? 1'b1 : (rx_byte == CMD_INV_OFF) ? 1'b0 : inversion_q;
            display_on_d = (rx_byte == CMD_DISP_ON) ? 1'b1 : (rx_byte == CMD_DISP_OFF) ? 1'b0 : display_on_q;
        end else if (rx_valid && state_q == ST_ARG1) begin
            arg_d = rx_byte;
            contrast_d = (op_q == CMD_CONTRAST) ? rx_byte : contrast_q;
            state_d = (op_q == CMD_COL_ADDR || op_q == CMD_PAGE_ADDR) ? ST_ARG2 : ST_CMD;
        end else if (rx_valid) begin
            // Window changes land only once both arguments have arrived.
            state_d = ST_CMD;
            if (op_q == CMD_COL_ADDR) begin
                col_start_d = arg_q[CW-1:0];
                col_end_d = rx_byte[CW-1:0];
                col_d = arg_q[CW-1:0];
            end else begin
                page_start_d = arg_q[PW-1:0];
                page_end_d = rx_byte[PW-1:0];
                page_d = arg_q[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CMD;
            op_q <= '0;
            arg_q <= '0;
            col_q <= '0;
            col_start_q <= '0;
            col_end_q <= CW'(FB_COLS - 1);
            page_q <= '0;
            page_start_q <= '0;
            page_end_q <= PW'(FB_PAGES - 1);
            fb_we_q <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            contrast_q <= RESET_CONTRAST;
            inversion_q <= 1'b0;
            display_on_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            arg_q <= arg_d;
            col_q <= col_d;
            col_start_q <= col_start_d;
            col_end_q <= col_end_d;
            page_q <= page_d;
            page_start_q <= page_start_d;
            page_end_q <= page_end_d;
            fb_we_q <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            contrast_q <= contrast_d;
            inversion_q <= inversion_d;
            display_on_q <= display_on_d;
        end
    end

    assign fb_we = fb_we_q;
    assign fb_addr = fb_addr_q;
    assign fb_data = fb_data_q;
    assign contrast = contrast_q;
    assign inversion = inversion_q;
    assign display_on = display_on_q;

`ifdef SSD1306_SINK_STATS_EN
    logic [15:0] cmd_count_q, cmd_count_d, data_count_q, data_count_d;
    logic [7:0]  error_count_q, error_count_d;

    always_comb begin
        cmd_count_d = cmd_count_q + {15'd0, rx_valid && !rx_is_data && cmd_count_q != 16'hFFFF};
        data_count_d = data_count_q + {15'd0, rx_valid && rx_is_data && data_count_q != 16'hFFFF};
        error_count_d = error_count_q + {7'd0, frame_error && error_count_q != 8'hFF};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_count_q <= '0;
            data_count_q <= '0;
            error_count_q <= '0;
        end else begin
            cmd_count_q <= cmd_count_d;
            data_count_q <= data_count_d;
            error_count_q <= error_count_d;
        end
    end

    assign cmd_count = cmd_count_q;
    assign data_count = data_count_q;
    assign error_count = error_count_q;
`endif
endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// tb_ssd1306_spi_sink: drives SPI byte streams into the sink and scores writes and status against a command-list model.
module tb_ssd1306_spi_sink;
    localparam int COLS = 128;
    localparam int PAGES = 8;
    localparam int SYNC = 2;
    localparam int HALF = SYNC + 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic spi_csn = 1'b1;
    logic spi_clk = 1'b0;
    logic spi_dcn = 1'b0;
    logic spi_mosi = 1'b0;
    logic fb_we, inversion, display_on, frame_error;
    logic [9:0] fb_addr;
    logic [7:0] fb_data, contrast;
`ifdef SSD1306_SINK_STATS_EN
    logic [15:0] cmd_count, data_count;
    logic [7:0] error_count;
`endif

    always #5 clk = ~clk;

    ssd1306_spi_sink #(.FB_COLS(COLS), .FB_PAGES(PAGES), .SYNC_STAGES(SYNC)) dut (
        .clk(clk),
        .reset(reset),
        .spi_csn(spi_csn),
        .spi_clk(spi_clk),
        .spi_dcn(spi_dcn),
        .spi_mosi(spi_mosi),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .contrast(contrast),
        .inversion(inversion),
        .display_on(display_on),
`ifdef SSD1306_SINK_STATS_EN
        .cmd_count(cmd_count),
        .data_count(data_count),
        .error_count(error_count),
`endif
        .frame_error(frame_error)
    );

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    int ferr_exp = 0;
    int lat = -1;
    logic [17:0] exp_q[$];

    int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_cmd, m_data;
    logic [7:0] m_contrast;
    logic m_inv, m_on;
    logic [7:0] cbuf[$];
    logic [7:0] ops[12] = '{8'h81, 8'h21, 8'h22, 8'hA6, 8'hA7, 8'hAE, 8'hAF, 8'h20, 8'h8D, 8'hE3, 8'h00, 8'hB0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && fb_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write", fb_addr, fb_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({fb_addr, fb_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %h expected addr %0d data %h", fb_addr, fb_data, e[17:8], e[7:0]);
                end
            end
        end
        if (reset && frame_error) ferr_seen++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    function automatic int arg_len(input logic [7:0] op);
        case (op)
            8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: return 2;
            8'h21, 8'h22: return 3;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1; m_ps = 0; m_pe = PAGES - 1;
        m_contrast = 8'h7F; m_inv = 1'b0; m_on = 1'b0; m_cmd = 0; m_data = 0;
        cbuf.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input logic dc);
        if (dc) begin
            exp_q.push_back({10'(m_page * COLS + m_col), b});
            if (m_col == m_ce) begin
                m_col = m_cs;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
            end else begin
                m_col = (m_col + 1) % COLS;
            end
            cbuf.delete();
            m_data++;
        end else begin
            m_cmd++;
            cbuf.push_back(b);
            if (cbuf.size() == arg_len(cbuf[0])) begin
                case (cbuf[0])
                    8'h81: m_contrast = cbuf[1];
                    8'h21: begin m_cs = int'(cbuf[1]) % COLS; m_ce = int'(cbuf[2]) % COLS; m_col = m_cs; end
                    8'h22: begin m_ps = int'(cbuf[1]) % PAGES; m_pe = int'(cbuf[2]) % PAGES; m_page = m_ps; end
                    8'hA6: m_inv = 1'b0;
                    8'hA7: m_inv = 1'b1;
                    8'hAE: m_on = 1'b0;
                    8'hAF: m_on = 1'b1;
                    default: ;
                endcase
                cbuf.delete();
            end
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int n, input bit timed);
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            spi_mosi = b[i];
            spi_dcn = dc;
            repeat (HALF - 1) @(negedge clk);
            spi_clk = 1'b1;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (timed && i == 0 && fb_we && lat < 0) lat = k;
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input bit timed = 1'b0);
        model_byte(b, dc);
        send_bits(b, dc, 8, timed);
    endtask

    task automatic begin_frame();
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        spi_csn = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d writes outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_status(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_contrast"}, contrast, m_contrast);
        check({tag, "_inversion"}, inversion, m_inv);
        check({tag, "_display_on"}, display_on, m_on);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fb_we"}, fb_we, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_fb_data"}, fb_data, 0);
        check({tag, "_contrast"}, contrast, 8'h7F);
        check({tag, "_inversion"}, inversion, 0);
        check({tag, "_display_on"}, display_on, 0);
        check({tag, "_frame_error"}, frame_error, 0);
    endtask

    initial begin
        model_reset();
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        begin_frame();
        send_byte(8'h81, 1'b0);
        send_byte(8'h3C, 1'b0);
        check_status("contrast_cmd");

        for (int i = 0; i < 130; i++) send_byte(8'(i), 1'b1, i == 0);
        check("write_latency", lat, SYNC + 2);
        drain();

        send_byte(8'h21, 1'b0); send_byte(8'h04, 1'b0); send_byte(8'h05, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h07, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 1'b1);
        drain();

        send_byte(8'hA7, 1'b0);
        send_byte(8'hAF, 1'b0);
        check_status("flags_on");
        send_byte(8'hE3, 1'b0);
        check_status("nop");
        send_byte(8'hA6, 1'b0);
        check_status("after_nop");

        end_frame();
        begin_frame();
        send_bits(8'h5A, 1'b0, 5, 1'b0);
        end_frame();
        ferr_exp++;
        check("frame_error_pulses", ferr_seen, ferr_exp);
        begin_frame();
        send_byte(8'hA5, 1'b1);
        drain();
        check("data_after_error", fb_data, 8'hA5);

        send_byte(8'h81, 1'b0);
        send_byte(8'h55, 1'b1);
        drain();
        check_status("abort");

        for (int i = 0; i < 150; i++) begin
            logic [7:0] b;
            logic dc;
            dc = $urandom_range(0, 2) != 0;
            b = dc ? 8'($urandom) : ($urandom_range(0, 3) == 0) ? 8'($urandom) : ops[$urandom_range(0, 11)];
            send_byte(b, dc);
            if ($urandom_range(0, 9) == 0) begin
                end_frame();
                begin_frame();
            end
        end
        drain();
        check_status("random");
        check("random_frame_error_pulses", ferr_seen, ferr_exp);

        send_byte(8'h81, 1'b0);
        send_bits(8'hF0, 1'b0, 4, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        spi_csn = 1'b1;
        spi_clk = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_reset_outputs("post_reset");
        begin_frame();
        send_byte(8'h77, 1'b1);
        drain();
        check_status("post_reset_status");
        end_frame();

`ifdef SSD1306_SINK_STATS_EN
        check("data_count", data_count, m_data);
        check("cmd_count", cmd_count, m_cmd);
`endif
        check("frame_error_final", ferr_seen, ferr_exp);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
